// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-bus signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;

  modport slave (
    input  imem_valid, imem_addr,
    input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    input  mem_ready, mem_rdata,
    output imem_ready, imem_rdata,
    output dmem_ready, dmem_rdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_error
  );

  modport master (
    output imem_valid, imem_addr,
    output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    output mem_ready, mem_rdata,
    input  imem_ready, imem_rdata,
    input  dmem_ready, dmem_rdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for the single core memory port, data-first with starvation bound.
// Define MEM_ARBITER_TIMEOUT_EN to add a watchdog that aborts a stalled transaction after TIMEOUT cycles.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        instr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        abort;
  logic        done;
  logic        grant_d;

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 2) begin : g_param_check
    $error("mem_arbiter: STARVE_MAX must be 1..15 and TIMEOUT at least 2");
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [WD_W-1:0] wdog;

  // Zeroed while idle so every busy state starts counting from its first cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == IDLE) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WD_W'(1);
    end
  end

  assign abort = (state != IDLE) && !bus.mem_ready && (wdog == WD_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  assign done    = (state != IDLE) && (bus.mem_ready || abort);
  // Data wins unless fetch is also waiting and has already been passed over STARVE_MAX times.
  assign grant_d = bus.dmem_valid && (!bus.imem_valid || (starve_cnt < 4'(STARVE_MAX)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      instr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= DBUSY;
            instr_q    <= 1'b0;
            addr_q     <= bus.dmem_addr;
            wdata_q    <= bus.dmem_wdata;
            wstrb_q    <= bus.dmem_wstrb;
            starve_cnt <= bus.imem_valid ? starve_cnt + 4'd1 : '0;
          end else if (bus.imem_valid) begin
            state      <= IBUSY;
            instr_q    <= 1'b1;
            addr_q     <= bus.imem_addr;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            starve_cnt <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = (state != IDLE);
  assign bus.mem_instr = instr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_error = abort;

  // abort implies !mem_ready, so an aborted owner sees zero data.
  assign bus.imem_ready = done && (state == IBUSY);
  assign bus.dmem_ready = done && (state == DBUSY);
  assign bus.imem_rdata = ((state == IBUSY) && bus.mem_ready) ? bus.mem_rdata : '0;
  assign bus.dmem_rdata = ((state == DBUSY) && bus.mem_ready) ? bus.mem_rdata : '0;

endmodule
